// File: rtl/sc_io_port.sv
// sc_io_port: memory-mapped slide-switch / seven-segment / LED port.
// Four word registers live in a 16-byte window at IO_BASE: SW (debounced
// switches), HEX (six hex digits), LED, and STATUS (sticky change flag with
// write-1-to-clear plus a count of accepted switch changes). Reads are
// combinational from addr; writes land on the rising clock edge.
module sc_io_port #(
   parameter logic [31:0] IO_BASE         = 32'h0000_0080,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   input  logic [9:0]  sw_in,
   output logic [23:0] hex_out,
   output logic [9:0]  led_out,
   output logic        sw_chg
);

   // Debounce FSM encoding.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_COUNT = 1'b1;

   // Counter value at which a steady change is accepted on the next edge.
   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   // Register select codes from addr[3:2].
   localparam logic [1:0] REG_SW     = 2'd0;
   localparam logic [1:0] REG_HEX    = 2'd1;
   localparam logic [1:0] REG_LED    = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   logic [9:0]  sw_meta_r;
   logic [9:0]  sw_sync_r;
   logic [9:0]  sw_prev_r;
   logic [9:0]  sw_stable_r;
   logic [0:0]  state_r;
   logic [0:0]  state_nxt_s;
   logic [15:0] cnt_r;
   logic [15:0] cnt_nxt_s;
   logic        accept_s;
   logic        sw_chg_r;
   logic        sw_chg_nxt_s;
   logic [15:0] accept_cnt_r;
   logic [23:0] hex_r;
   logic [9:0]  led_r;

   logic        in_win_s;
   logic [1:0]  sel_s;
   logic        wr_hex_s;
   logic        wr_led_s;
   logic        wr_clr_s;

   assign in_win_s = (addr[31:4] == IO_BASE[31:4]);
   assign sel_s    = addr[3:2];
   assign wr_hex_s = we && in_win_s && (sel_s == REG_HEX);
   assign wr_led_s = we && in_win_s && (sel_s == REG_LED);
   assign wr_clr_s = we && in_win_s && (sel_s == REG_STATUS) && wdata[0];

   assign hex_out = hex_r;
   assign led_out = led_r;
   assign sw_chg  = sw_chg_r;

   // Two-flop synchronizer for the raw switch levels, plus a one-cycle history.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_meta_r <= 10'd0;
         sw_sync_r <= 10'd0;
         sw_prev_r <= 10'd0;
      end else begin
         sw_meta_r <= sw_in;
         sw_sync_r <= sw_meta_r;
         sw_prev_r <= sw_sync_r;
      end
   end

   // Debounce next-state: restart on any bit movement, accept after a full steady window.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      accept_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (sw_sync_r != sw_stable_r) begin
               state_nxt_s = ST_COUNT;
               cnt_nxt_s   = 16'd1;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 16'd0;
            end
         end
         ST_COUNT: begin
            if (sw_sync_r == sw_stable_r) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 16'd0;
            end else if (sw_sync_r != sw_prev_r) begin
               state_nxt_s = ST_COUNT;
               cnt_nxt_s   = 16'd1;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 16'd0;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = ST_COUNT;
               cnt_nxt_s   = cnt_r + 16'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 16'd0;
         end
      endcase
   end

   // Debounce state, counter and accepted switch vector.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 16'd0;
         sw_stable_r <= 10'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (accept_s) begin
            sw_stable_r <= sw_sync_r;
         end else begin
            sw_stable_r <= sw_stable_r;
         end
      end
   end

   // Sticky change flag: a same-edge accept overrides a write-1-to-clear.
   always_comb begin
      sw_chg_nxt_s = sw_chg_r;
      if (accept_s) begin
         sw_chg_nxt_s = 1'b1;
      end else if (wr_clr_s) begin
         sw_chg_nxt_s = 1'b0;
      end else begin
         sw_chg_nxt_s = sw_chg_r;
      end
   end

   // Status flag and wrapping accept counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_chg_r     <= 1'b0;
         accept_cnt_r <= 16'd0;
      end else begin
         sw_chg_r <= sw_chg_nxt_s;
         if (accept_s) begin
            accept_cnt_r <= accept_cnt_r + 16'd1;
         end else begin
            accept_cnt_r <= accept_cnt_r;
         end
      end
   end

   // CPU-writable HEX and LED registers; upper write bits are dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hex_r <= 24'd0;
         led_r <= 10'd0;
      end else begin
         if (wr_hex_s) begin
            hex_r <= wdata[23:0];
         end else begin
            hex_r <= hex_r;
         end
         if (wr_led_s) begin
            led_r <= wdata[9:0];
         end else begin
            led_r <= led_r;
         end
      end
   end

   // Zero-latency read mux; anything outside the window reads as zero.
   always_comb begin
      rdata = 32'd0;
      if (in_win_s) begin
         case (sel_s)
            REG_SW:     rdata = {22'd0, sw_stable_r};
            REG_HEX:    rdata = {8'd0, hex_r};
            REG_LED:    rdata = {22'd0, led_r};
            REG_STATUS: rdata = {accept_cnt_r, 15'd0, sw_chg_r};
            default:    rdata = 32'd0;
         endcase
      end else begin
         rdata = 32'd0;
      end
   end

endmodule

// File: tb/tb_sc_io_port.sv
// Directed bench for sc_io_port: a register-access vector table followed by
// hand-written sequences for debounce latency, glitch rejection, the
// accept/clear collision and reset during a pending debounce.
module tb_sc_io_port;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic [9:0]  sw_in;
   logic [23:0] hex_out;
   logic [9:0]  led_out;
   logic        sw_chg;

   int n_vec;
   int n_err;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [23:0] exp_hex;
      logic [9:0]  exp_led;
   } vec_t;

   vec_t vecs[13];

   sc_io_port #(
      .IO_BASE         (32'h0000_0080),
      .DEBOUNCE_CYCLES (16)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .addr    (addr),
      .wdata   (wdata),
      .we      (we),
      .rdata   (rdata),
      .sw_in   (sw_in),
      .hex_out (hex_out),
      .led_out (led_out),
      .sw_chg  (sw_chg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      we    = 1'b0;
      addr  = 32'h0000_0080;
      wdata = 32'd0;
      sw_in = 10'd0;

      vecs[0]  = '{1'b1, 32'h0000_0084, 32'hFFAB_CDEF, 32'h00AB_CDEF, 24'hABCDEF, 10'h000};
      vecs[1]  = '{1'b0, 32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 24'hABCDEF, 10'h000};
      vecs[2]  = '{1'b0, 32'h0000_0090, 32'h0000_0000, 32'h0000_0000, 24'hABCDEF, 10'h000};
      vecs[3]  = '{1'b1, 32'h0000_0088, 32'hFFFF_FFFF, 32'h0000_03FF, 24'hABCDEF, 10'h3FF};
      vecs[4]  = '{1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0000_0000, 24'hABCDEF, 10'h3FF};
      vecs[5]  = '{1'b1, 32'h0000_00A0, 32'h5555_5555, 32'h0000_0000, 24'hABCDEF, 10'h3FF};
      vecs[6]  = '{1'b0, 32'h0000_0084, 32'h0000_0000, 32'h00AB_CDEF, 24'hABCDEF, 10'h3FF};
      vecs[7]  = '{1'b0, 32'h0000_008B, 32'h0000_0000, 32'h0000_03FF, 24'hABCDEF, 10'h3FF};
      vecs[8]  = '{1'b1, 32'h0000_008C, 32'hFFFF_FFFF, 32'h0000_0000, 24'hABCDEF, 10'h3FF};
      vecs[9]  = '{1'b1, 32'h0000_008A, 32'h0000_0155, 32'h0000_0155, 24'hABCDEF, 10'h155};
      vecs[10] = '{1'b1, 32'h1000_0084, 32'h1234_5678, 32'h0000_0000, 24'hABCDEF, 10'h155};
      vecs[11] = '{1'b1, 32'h0000_0086, 32'h0000_0012, 32'h0000_0012, 24'h000012, 10'h155};
      vecs[12] = '{1'b0, 32'h0000_0080, 32'h0000_0000, 32'h0000_0000, 24'h000012, 10'h155};

      // Reset state, and a store attempted while reset is held.
      tick();
      tick();
      addr  = 32'h0000_0084;
      wdata = 32'h00FF_FFFF;
      we    = 1'b1;
      tick();
      we    = 1'b0;
      chk("reset_hex", {8'd0, hex_out}, 32'd0);
      chk("reset_led", {22'd0, led_out}, 32'd0);
      chk("reset_swchg", {31'd0, sw_chg}, 32'd0);
      rd(32'h0000_0084, d);
      chk("reset_hex_rd", d, 32'd0);
      rd(32'h0000_008C, d);
      chk("reset_status", d, 32'd0);
      reset = 1'b0;
      tick();

      // Register access table.
      for (int i = 0; i < 13; i++) begin
         addr  = vecs[i].addr;
         wdata = vecs[i].wdata;
         we    = vecs[i].we;
         tick();
         we = 1'b0;
         #1;
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_hex", i), {8'd0, hex_out}, {8'd0, vecs[i].exp_hex});
         chk($sformatf("vec%0d_led", i), {22'd0, led_out}, {22'd0, vecs[i].exp_led});
      end

      // Debounce latency: 0 -> 2A5 accepted exactly on edge 18.
      addr  = 32'h0000_0080;
      sw_in = 10'h2A5;
      for (int e = 1; e <= 17; e++) begin
         tick();
         chk($sformatf("lat_sw_e%0d", e), rdata, 32'd0);
      end
      tick();
      rd(32'h0000_0080, d);
      chk("lat_sw_e18", d, 32'h0000_02A5);
      chk("lat_swchg_e18", {31'd0, sw_chg}, 32'd1);
      rd(32'h0000_008C, d);
      chk("lat_status_e18", d, 32'h0001_0001);

      // Accept and write-1-to-clear on the same edge: set wins.
      sw_in = 10'h000;
      for (int e = 1; e <= 17; e++) begin
         tick();
      end
      rd(32'h0000_0080, d);
      chk("col_sw_e17", d, 32'h0000_02A5);
      wr(32'h0000_008C, 32'h0000_0001);
      chk("col_swchg", {31'd0, sw_chg}, 32'd1);
      rd(32'h0000_008C, d);
      chk("col_status", d, 32'h0002_0001);
      rd(32'h0000_0080, d);
      chk("col_sw", d, 32'd0);
      wr(32'h0000_008C, 32'h0000_0000);
      chk("w0_keeps_swchg", {31'd0, sw_chg}, 32'd1);
      wr(32'h0000_008C, 32'h0000_0001);
      chk("clr_swchg", {31'd0, sw_chg}, 32'd0);
      rd(32'h0000_008C, d);
      chk("clr_status", d, 32'h0002_0000);

      // Glitch rejection: a 10-cycle pulse never reaches SW.
      do_reset();
      repeat (4) tick();
      sw_in = 10'h001;
      repeat (10) tick();
      sw_in = 10'h000;
      repeat (40) tick();
      rd(32'h0000_0080, d);
      chk("glitch_sw", d, 32'd0);
      chk("glitch_swchg", {31'd0, sw_chg}, 32'd0);
      rd(32'h0000_008C, d);
      chk("glitch_status", d, 32'd0);

      // Reset mid-debounce abandons the pending change.
      wr(32'h0000_0084, 32'h0012_3456);
      wr(32'h0000_0088, 32'h0000_02AA);
      chk("pre_rst_hex", {8'd0, hex_out}, 32'h0012_3456);
      sw_in = 10'h3FF;
      repeat (9) tick();
      reset = 1'b1;
      #1;
      chk("rst_async_hex", {8'd0, hex_out}, 32'd0);
      chk("rst_async_led", {22'd0, led_out}, 32'd0);
      chk("rst_async_swchg", {31'd0, sw_chg}, 32'd0);
      repeat (3) tick();
      rd(32'h0000_0080, d);
      chk("rst_sw", d, 32'd0);
      rd(32'h0000_008C, d);
      chk("rst_status", d, 32'd0);
      reset = 1'b0;
      addr  = 32'h0000_0080;
      repeat (17) tick();
      chk("rerun_sw_e17", rdata, 32'd0);
      tick();
      chk("rerun_sw_e18", rdata, 32'h0000_03FF);
      chk("rerun_swchg_e18", {31'd0, sw_chg}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sc_io_port.md
SC_IO_PORT -- requirements
Module: sc_io_port

Interface
REQ-001 Parameter IO_BASE, default 32'h0000_0080, word-aligned base address of the 16-byte I/O register window.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, range 2..65535, stable-input cycles required before a switch change is accepted.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  rising-edge clock, shared with the CPU.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr  input  32  CPU data-bus byte address.
REQ-007 wdata  input  32  CPU store data.
REQ-008 we  input  1  CPU store strobe.
REQ-009 rdata  output  32  load data, combinational from addr.
REQ-010 sw_in  input  10  raw asynchronous slide-switch levels.
REQ-011 hex_out  output  24  six 4-bit hex digits for the seven-segment decoders; digit 0 is [3:0].
REQ-012 led_out  output  10  LED drive.
REQ-013 sw_chg  output  1  sticky switch-change flag.

Function
REQ-014 The window is addr[31:4]==IO_BASE[31:4]. The register is selected by addr[3:2]; addr[1:0] is ignored.
  - 0 SW: read-only, {22'b0, sw_stable}.
  - 1 HEX: read/write, [23:0].
  - 2 LED: read/write, [9:0].
  - 3 STATUS: bit0 = sw_chg (write-1-to-clear), [31:16] = accept_cnt (read-only), all other bits 0.
REQ-015 rdata SHALL be valid in the same cycle as addr (zero-latency read); it is 0 when addr is outside the window.
REQ-016 A write SHALL take effect on the rising edge where we=1 and addr is in the window.
  - Unused upper bits of written registers are discarded; they read back as 0.
  - Writes to SW, or outside the window, have no effect.
REQ-017 hex_out and led_out SHALL drive the HEX and LED registers directly, with no output latency beyond the write edge.
REQ-018 sw_in SHALL pass through a 2-flop synchronizer, giving sw_sync.
REQ-019 The debounce FSM has two states, IDLE and COUNT, and a 16-bit counter cnt.
  - IDLE: if sw_sync != sw_stable, go to COUNT with cnt=1; otherwise stay.
  - COUNT, sw_sync == sw_stable: go to IDLE with cnt=0 (glitch rejected).
  - COUNT, sw_sync changed from its previous-cycle value: restart with cnt=1.
  - COUNT, cnt == DEBOUNCE_CYCLES-1 and sw_sync steady: on the next edge, sw_stable<=sw_sync, sw_chg<=1, accept_cnt<=accept_cnt+1 (wraps 16'hFFFF->0), go to IDLE with cnt=0.
  - Otherwise, in COUNT: cnt<=cnt+1.
REQ-020 A steady sw_in change SHALL appear on SW and sw_chg exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new sw_in.
REQ-021 If an accept event and a write-1-to-clear of STATUS bit0 fall on the same edge, the set SHALL win and sw_chg stays 1.
REQ-022 A STATUS write with bit0=0 SHALL leave sw_chg unchanged.
REQ-023 Any change of any switch bit during COUNT SHALL restart the whole debounce window; acceptance is whole-vector, not per-bit.

Reset
REQ-024 While reset=1, the following SHALL be 0, independent of clock: sync flops, sw_stable, cnt, sw_chg, accept_cnt, HEX, LED, rdata-visible SW.
  - The FSM is held in IDLE.
REQ-025 Reset asserted mid-COUNT SHALL abandon the pending change.
  - After release, a still-different sw_in is re-debounced from cnt=0 and takes a full 2+DEBOUNCE_CYCLES edges.
REQ-026 Writes with we=1 during reset SHALL be ignored.

Verification
REQ-027 Register access, reset released, sw_in=0:
  - Write HEX 32'hFFAB_CDEF at IO_BASE+4, then read it -> 32'h00AB_CDEF, and hex_out=24'hABCDEF on the edge after the write.
  - Read IO_BASE+8 -> 0.
  - Read IO_BASE+16 -> 0.
REQ-028 Debounce latency, DEBOUNCE_CYCLES=16: step sw_in 0->10'h2A5 and hold ->
  - SW reads 0 through edge 17.
  - Edge 18: SW reads 32'h2A5, sw_chg=1, STATUS=32'h0001_0001.
REQ-029 Glitch rejection, DEBOUNCE_CYCLES=16: pulse sw_in to 10'h001 for 10 cycles, then back to 0 -> SW stays 0, sw_chg stays 0, accept_cnt stays 0.
REQ-030 W1C collision, with sw_chg=1 pending:
  - Write 1 to STATUS bit0 on the same edge as a new accept -> sw_chg=1 and accept_cnt increments.
  - A later write of 1 with no accept on that edge -> sw_chg=0.
REQ-031 Reset mid-debounce: hold sw_in=10'h3FF, assert reset at edge 10 for 3 cycles ->
  - All outputs read 0 during reset.
  - SW becomes 10'h3FF exactly 18 edges after the release edge.
REQ-032 Write filtering, HEX and LED nonzero:
  - Store to IO_BASE+0 and to IO_BASE+32 -> HEX, LED and SW unchanged.
  - Store 32'hFFFF_FFFF to LED -> led_out=10'h3FF, and a LED read returns 32'h0000_03FF.
